simon_sequencer: RTL

- Parametrised Simon game engine.
- Grows a random pad sequence one step per round, plays it back on the pad LEDs, then checks the player's presses against it.
- Sits between the per-pad debouncers and LFSR on the input side, and the LED controller and LCD status logic on the output side.
- Generalises the single-colour echo path to N pads, configurable sequence length and timing, with an input timeout and win/lose detection.

---
 rtl/simon_sequencer_if.sv | 29 ++
 rtl/simon_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/simon_sequencer_if.sv
// Handshake/bus bundle between the Simon sequencer and its pad, LFSR and LED neighbours.
// The testbench or top level drives the master side; the sequencer uses the slave side.
interface simon_sequencer_if #(
   parameter int NUM_PADS = 4,
   parameter int MAX_LEN  = 32
);
   localparam int PAD_W = (NUM_PADS > 2) ? $clog2(NUM_PADS) : 1;
   localparam int LEN_W = $clog2(MAX_LEN + 1);

   logic                start;
   logic [NUM_PADS-1:0] pad_pressed;
   logic [PAD_W-1:0]    rand_pad;
   logic                rand_step;
   logic                led_en;
   logic [PAD_W-1:0]    led_color;
   logic [2:0]          state_code;
   logic [LEN_W-1:0]    score;
   logic                game_over;

   modport master (
      output start, pad_pressed, rand_pad,
      input  rand_step, led_en, led_color, state_code, score, game_over
   );

   modport slave (
      input  start, pad_pressed, rand_pad,
      output rand_step, led_en, led_color, state_code, score, game_over
   );
endinterface

// File: rtl/simon_sequencer.sv
// Simon game engine: grows a random pad sequence, plays it back, then checks the player's presses.
// Optional macro SIMON_SPEEDUP_EN shortens show/gap times as the score rises.
module simon_sequencer #(
   parameter int NUM_PADS       = 4,
   parameter int MAX_LEN        = 32,
   parameter int SHOW_CYCLES    = 50000000,
   parameter int GAP_CYCLES     = 25000000,
   parameter int TIMEOUT_CYCLES = 250000000
) (
   input logic              clk,
   input logic              reset,
   simon_sequencer_if.slave bus
);
   localparam int PAD_W = (NUM_PADS > 2) ? $clog2(NUM_PADS) : 1;
   localparam int LEN_W = $clog2(MAX_LEN + 1);
   localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int TMAX  = (SHOW_CYCLES > GAP_CYCLES)
                          ? ((SHOW_CYCLES > TIMEOUT_CYCLES) ? SHOW_CYCLES : TIMEOUT_CYCLES)
                          : ((GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES);
   localparam int TW    = $clog2(TMAX + 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ADD       = 3'd1,
      S_SHOW_ON   = 3'd2,
      S_SHOW_OFF  = 3'd3,
      S_WAIT_IN   = 3'd4,
      S_ROUND_GAP = 3'd5,
      S_WIN       = 3'd6,
      S_LOSE      = 3'd7
   } state_e;

   state_e           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] score_q, score_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic             led_en_q, led_en_d;
   logic [PAD_W-1:0] led_color_q, led_color_d;
   logic             rand_step_q, rand_step_d;
   logic             game_over_q, game_over_d;

   logic [PAD_W-1:0] seq_q [MAX_LEN];
   logic             seq_we;
   logic [PAD_W-1:0] new_pad;
   logic             last_step;
   logic             good_press;
   logic [TW-1:0]    show_lim, gap_lim;

   assign new_pad    = PAD_W'(32'(bus.rand_pad) % 32'(NUM_PADS));
   assign last_step  = (LEN_W'(idx_q) + LEN_W'(1)) == len_q;
   assign good_press = $onehot(bus.pad_pressed)
                       && (bus.pad_pressed == (NUM_PADS'(1) << seq_q[idx_q]));

   // Terminal counts are stored as (cycles - 1) so the timer compares directly.
`ifdef SIMON_SPEEDUP_EN
   logic [TW-1:0] show_lim_q, gap_lim_q;

   function automatic logic [TW-1:0] eff_lim(input int base, input logic [LEN_W-1:0] sc);
      int t;
      t = base >> (int'(sc) / 8);
      if (t < base / 4) t = base / 4;
      if (t < 1) t = 1;
      return TW'(t - 1);
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         show_lim_q <= TW'(SHOW_CYCLES - 1);
         gap_lim_q  <= TW'(GAP_CYCLES - 1);
      end else if (state_d == S_ADD && state_q != S_ADD) begin
         show_lim_q <= eff_lim(SHOW_CYCLES, score_d);
         gap_lim_q  <= eff_lim(GAP_CYCLES, score_d);
      end
   end

   assign show_lim = show_lim_q;
   assign gap_lim  = gap_lim_q;
`else
   assign show_lim = TW'(SHOW_CYCLES - 1);
   assign gap_lim  = TW'(GAP_CYCLES - 1);
`endif

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      idx_d       = idx_q;
      timer_d     = timer_q;
      score_d     = score_q;
      led_color_d = led_color_q;
      seq_we      = 1'b0;

      case (state_q)
         S_IDLE, S_LOSE: begin
            if (bus.start) begin
               state_d = S_ADD;
               len_d   = '0;
               score_d = '0;
               timer_d = '0;
            end
         end

         S_WIN: begin
            if (bus.start) begin
               state_d = S_ADD;
               len_d   = '0;
               score_d = '0;
               timer_d = '0;
            end else if (timer_q == show_lim) begin
               timer_d     = '0;
               led_color_d = (led_color_q == PAD_W'(NUM_PADS - 1)) ? '0
                                                                   : led_color_q + PAD_W'(1);
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end

         S_ADD: begin
            seq_we  = 1'b1;
            len_d   = len_q + LEN_W'(1);
            idx_d   = '0;
            timer_d = '0;
            state_d = S_SHOW_ON;
         end

         S_SHOW_ON: begin
            if (timer_q == show_lim) begin
               timer_d = '0;
               state_d = S_SHOW_OFF;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end

         S_SHOW_OFF: begin
            if (timer_q == gap_lim) begin
               timer_d = '0;
               if (last_step) begin
                  idx_d   = '0;
                  state_d = S_WAIT_IN;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = S_SHOW_ON;
               end
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end

         S_WAIT_IN: begin
            // A press is evaluated before the timeout, so a press on the last allowed cycle wins.
            if (bus.pad_pressed != '0) begin
               if (good_press) begin
                  timer_d = '0;
                  if (!last_step) begin
                     idx_d = idx_q + IDX_W'(1);
                  end else begin
                     score_d = len_q;
                     if (len_q == LEN_W'(MAX_LEN)) begin
                        state_d     = S_WIN;
                        led_color_d = '0;
                     end else begin
                        state_d = S_ROUND_GAP;
                     end
                  end
               end else begin
                  state_d = S_LOSE;
               end
            end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
               state_d = S_LOSE;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end

         S_ROUND_GAP: begin
            if (timer_q == gap_lim) begin
               timer_d = '0;
               state_d = S_ADD;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end

         default: state_d = S_IDLE;
      endcase

      // seq[0] is written in the same cycle the first playback colour is chosen.
      if (state_d == S_SHOW_ON) begin
         led_color_d = (seq_we && len_q == '0) ? new_pad : seq_q[idx_d];
      end

      led_en_d    = (state_d == S_SHOW_ON) || (state_d == S_WIN);
      rand_step_d = (state_d == S_ADD);
      game_over_d = (state_d == S_WIN) || (state_d == S_LOSE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         idx_q       <= '0;
         timer_q     <= '0;
         score_q     <= '0;
         led_en_q    <= 1'b0;
         led_color_q <= '0;
         rand_step_q <= 1'b0;
         game_over_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         idx_q       <= idx_d;
         timer_q     <= timer_d;
         score_q     <= score_d;
         led_en_q    <= led_en_d;
         led_color_q <= led_color_d;
         rand_step_q <= rand_step_d;
         game_over_q <= game_over_d;
      end
   end

   always_ff @(posedge clk) begin
      if (seq_we) seq_q[IDX_W'(len_q)] <= new_pad;
   end

   assign bus.state_code = state_q;
   assign bus.score      = score_q;
   assign bus.led_en     = led_en_q;
   assign bus.led_color  = led_color_q;
   assign bus.rand_step  = rand_step_q;
   assign bus.game_over  = game_over_q;
endmodule
